map_bram_arbiter: RTL and testbench

- Shares the single read/write port of the map-tile SB_RAM40_4K between three requesters: the sprite/tile renderer (reads), the player collision checker (reads) and the lane scroller (reads and writes that shift car/log rows).
- Renderer has fixed priority. Collision and scroller alternate round-robin.
- A starvation counter guarantees the low-priority requesters forward progress.
- Sits between the game-logic modules and the BRAM primitive; the BRAM is instantiated outside this block.

---
 rtl/map_bram_pkg.sv | 23 ++
 rtl/bram_rr_pick2.sv | 34 +++
 rtl/map_bram_arbiter.sv | 152 +++++++++++++++
 tb/tb_map_bram_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/map_bram_pkg.sv
// Shared definitions for the map-tile BRAM arbiter: owner tags, default
// widths and the BRAM read latency.
package map_bram_pkg;

  // Owner tag carried alongside each BRAM access to route read data back.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_RND  = 2'd1,
    OWN_COL  = 2'd2,
    OWN_SCR  = 2'd3
  } owner_e;

  // Round-robin pointer between the two low-priority requesters.
  typedef enum logic {
    RR_COL = 1'b0,
    RR_SCR = 1'b1
  } rr_ptr_e;

  localparam int unsigned DEF_ADDR_W  = 11;
  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned BRAM_RD_LAT = 1;

endpackage

// File: rtl/bram_rr_pick2.sv
// Two-way round-robin picker for the collision (bit 0) and scroller (bit 1)
// requesters. A lone requester always wins; a tie goes to the pointer.
module bram_rr_pick2
  import map_bram_pkg::*;
(
  input  logic       i_Clk,
  input  logic       i_reset_n,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic [1:0] o_grant
);

  rr_ptr_e ptr_q;

  // Resolve a tie with the pointer, otherwise pass the lone request through.
  always_comb begin
    o_grant = '0;
    if (i_req == 2'b11) begin
      o_grant = (ptr_q == RR_COL) ? 2'b01 : 2'b10;
    end else begin
      o_grant = i_req;
    end
  end

  // After a used grant, point at the other requester.
  always_ff @(posedge i_Clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ptr_q <= RR_COL;
    end else if (i_take) begin
      ptr_q <= o_grant[0] ? RR_SCR : RR_COL;
    end
  end

endmodule

// File: rtl/map_bram_arbiter.sv
// Arbiter sharing the single map-tile BRAM port between the renderer
// (fixed priority), the collision checker and the lane scroller
// (round-robin), with a starvation counter that lets a waiting
// low-priority request pre-empt the renderer.
module map_bram_arbiter
  import map_bram_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              i_Clk,
  input  logic              i_reset_n,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_ack,
  output logic              o_rd_stall,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_col_req,
  input  logic [ADDR_W-1:0] i_col_addr,
  output logic              o_col_ack,
  output logic              o_col_valid,
  output logic [DATA_W-1:0] o_col_data,
  input  logic              i_scr_req,
  input  logic              i_scr_we,
  input  logic [ADDR_W-1:0] i_scr_addr,
  input  logic [DATA_W-1:0] i_scr_wdata,
  output logic              o_scr_ack,
  output logic              o_scr_valid,
  output logic [DATA_W-1:0] o_scr_data,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic              o_bram_re,
  output logic              o_bram_we,
  output logic [DATA_W-1:0] o_bram_wdata,
  input  logic [DATA_W-1:0] i_bram_rdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic             col_m, scr_m, low_pend, starve_hit;
  logic             g_rd, g_col, g_scr, stall;
  logic [1:0]       rr_grant;
  logic [CNT_W-1:0] starve_q;
  owner_e           issue_tag, tag0_q, tag1_q;

  // The registered ack doubles as the one-edge mask. The renderer streams
  // back-to-back reads and is deliberately left unmasked; masking it would
  // hand every other slot to the low-priority side and the starvation path
  // could never engage.
  assign col_m      = i_col_req & ~o_col_ack;
  assign scr_m      = i_scr_req & ~o_scr_ack;
  assign low_pend   = col_m | scr_m;
  assign starve_hit = (starve_q == CNT_W'(STARVE_LIMIT));

  bram_rr_pick2 u_pick (
    .i_Clk     (i_Clk),
    .i_reset_n (i_reset_n),
    .i_req     ({scr_m, col_m}),
    .i_take    (g_col | g_scr),
    .o_grant   (rr_grant)
  );

  // Choose at most one requester per edge and tag the access with its owner.
  always_comb begin
    g_rd      = 1'b0;
    g_col     = 1'b0;
    g_scr     = 1'b0;
    stall     = 1'b0;
    issue_tag = OWN_NONE;
    if (i_rd_req && !(starve_hit && low_pend)) begin
      g_rd = 1'b1;
    end else begin
      g_col = rr_grant[0];
      g_scr = rr_grant[1];
      stall = i_rd_req & (rr_grant != 2'b00);
    end
    if (g_rd) begin
      issue_tag = OWN_RND;
    end else if (g_col) begin
      issue_tag = OWN_COL;
    end else if (g_scr && !i_scr_we) begin
      issue_tag = OWN_SCR;
    end
  end

  // Register acks, stall and the BRAM command; the tag pipeline tracks reads.
  always_ff @(posedge i_Clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_rd_ack     <= 1'b0;
      o_col_ack    <= 1'b0;
      o_scr_ack    <= 1'b0;
      o_rd_stall   <= 1'b0;
      o_bram_addr  <= '0;
      o_bram_re    <= 1'b0;
      o_bram_we    <= 1'b0;
      o_bram_wdata <= '0;
      tag0_q       <= OWN_NONE;
      tag1_q       <= OWN_NONE;
    end else begin
      o_rd_ack   <= g_rd;
      o_col_ack  <= g_col;
      o_scr_ack  <= g_scr;
      o_rd_stall <= stall;
      o_bram_re  <= g_rd | g_col | (g_scr & ~i_scr_we);
      o_bram_we  <= g_scr & i_scr_we;
      if (g_rd) begin
        o_bram_addr <= i_rd_addr;
      end else if (g_col) begin
        o_bram_addr <= i_col_addr;
      end else if (g_scr) begin
        o_bram_addr <= i_scr_addr;
        if (i_scr_we) begin
          o_bram_wdata <= i_scr_wdata;
        end
      end
      tag0_q <= issue_tag;
      tag1_q <= tag0_q;
    end
  end

  // Count edges where a live low-priority request is passed over.
  always_ff @(posedge i_Clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      starve_q <= '0;
    end else if (g_col || g_scr || !low_pend) begin
      starve_q <= '0;
    end else if (!starve_hit) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  // Return read data to the owner recorded two edges earlier.
  always_ff @(posedge i_Clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_rd_valid  <= 1'b0;
      o_col_valid <= 1'b0;
      o_scr_valid <= 1'b0;
      o_rd_data   <= '0;
      o_col_data  <= '0;
      o_scr_data  <= '0;
    end else begin
      o_rd_valid  <= (tag1_q == OWN_RND);
      o_col_valid <= (tag1_q == OWN_COL);
      o_scr_valid <= (tag1_q == OWN_SCR);
      if (tag1_q == OWN_RND) o_rd_data  <= i_bram_rdata;
      if (tag1_q == OWN_COL) o_col_data <= i_bram_rdata;
      if (tag1_q == OWN_SCR) o_scr_data <= i_bram_rdata;
    end
  end

endmodule

// File: tb/tb_map_bram_arbiter.sv
// Bench for map_bram_arbiter: directed table and sequences plus random
// traffic, all checked against a transaction-level reference model.
module tb_map_bram_arbiter;

  localparam int AW  = 11;
  localparam int DW  = 16;
  localparam int LIM = 8;

  logic          i_Clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_rd_req = 1'b0, i_col_req = 1'b0, i_scr_req = 1'b0, i_scr_we = 1'b0;
  logic [AW-1:0] i_rd_addr = '0, i_col_addr = '0, i_scr_addr = '0;
  logic [DW-1:0] i_scr_wdata = '0;
  logic [DW-1:0] i_bram_rdata = '0;
  logic          o_rd_ack, o_rd_stall, o_rd_valid, o_col_ack, o_col_valid;
  logic          o_scr_ack, o_scr_valid, o_bram_re, o_bram_we;
  logic [DW-1:0] o_rd_data, o_col_data, o_scr_data, o_bram_wdata;
  logic [AW-1:0] o_bram_addr;

  map_bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .i_Clk(i_Clk), .i_reset_n(i_reset_n),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .o_rd_ack(o_rd_ack),
    .o_rd_stall(o_rd_stall), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
    .i_col_req(i_col_req), .i_col_addr(i_col_addr), .o_col_ack(o_col_ack),
    .o_col_valid(o_col_valid), .o_col_data(o_col_data),
    .i_scr_req(i_scr_req), .i_scr_we(i_scr_we), .i_scr_addr(i_scr_addr),
    .i_scr_wdata(i_scr_wdata), .o_scr_ack(o_scr_ack), .o_scr_valid(o_scr_valid),
    .o_scr_data(o_scr_data), .o_bram_addr(o_bram_addr), .o_bram_re(o_bram_re),
    .o_bram_we(o_bram_we), .o_bram_wdata(o_bram_wdata), .i_bram_rdata(i_bram_rdata)
  );

  always #5 i_Clk = ~i_Clk;

  function automatic logic [DW-1:0] init_pat(input logic [AW-1:0] a);
    return 16'h3320 ^ {5'b0, a};
  endfunction

  // BRAM stand-in: registered read, write on WE; unwritten words read a pattern.
  logic [DW-1:0] bmem [0:2047];
  bit            bwr  [0:2047];
  always @(posedge i_Clk) begin
    if (o_bram_we) begin
      bmem[o_bram_addr] <= o_bram_wdata;
      bwr[o_bram_addr]  <= 1'b1;
    end
    if (o_bram_re) i_bram_rdata <= bwr[o_bram_addr] ? bmem[o_bram_addr] : init_pat(o_bram_addr);
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: who was served last, whose turn a tie is, how long
  // the low side has waited, the memory contents and reads owed to owners.
  typedef struct { int due; int who; logic [DW-1:0] data; } deliv_t;
  deliv_t        m_q[$];
  logic [DW-1:0] m_mem [int];
  int            m_prev, m_next_low, m_denied, m_cyc;
  logic          e_ack[1:3], e_valid[1:3];
  logic [DW-1:0] e_data[1:3];
  logic          e_stall, e_re, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return m_mem.exists(int'(a)) ? m_mem[int'(a)] : init_pat(a);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_prev = 0; m_next_low = 2; m_denied = 0; m_cyc = 0;
    for (int k = 1; k <= 3; k++) begin
      e_ack[k] = 0; e_valid[k] = 0; e_data[k] = '0;
    end
    e_stall = 0; e_re = 0; e_we = 0; e_addr = '0; e_wdata = '0;
  endtask

  task automatic model_step();
    logic w_rd, w_col, w_scr, low_any, starving;
    int pick, win;
    logic [AW-1:0] a;
    m_cyc++;
    w_rd  = i_rd_req;
    w_col = i_col_req && (m_prev != 2);
    w_scr = i_scr_req && (m_prev != 3);
    low_any = w_col || w_scr;
    if (w_col && w_scr) pick = m_next_low;
    else if (w_col)     pick = 2;
    else if (w_scr)     pick = 3;
    else                pick = 0;
    starving = low_any && (m_denied >= LIM);
    win = (w_rd && !starving) ? 1 : pick;
    e_stall = w_rd && (win != 1);
    if (win >= 2)     m_denied = 0;
    else if (low_any) m_denied = (m_denied < LIM) ? m_denied + 1 : LIM;
    else              m_denied = 0;
    if (win == 2) m_next_low = 3;
    if (win == 3) m_next_low = 2;
    m_prev = win;
    for (int k = 1; k <= 3; k++) begin
      e_ack[k] = (win == k); e_valid[k] = 0;
    end
    e_re = 0; e_we = 0;
    if (win != 0) begin
      a = (win == 1) ? i_rd_addr : (win == 2) ? i_col_addr : i_scr_addr;
      e_addr = a;
      if (win == 3 && i_scr_we) begin
        e_we = 1; e_wdata = i_scr_wdata; m_mem[int'(a)] = i_scr_wdata;
      end else begin
        e_re = 1;
        m_q.push_back('{m_cyc + 2, win, mem_rd(a)});
      end
    end
    while (m_q.size() != 0 && m_q[0].due == m_cyc) begin
      e_valid[m_q[0].who] = 1;
      e_data[m_q[0].who]  = m_q[0].data;
      void'(m_q.pop_front());
    end
  endtask

  task automatic compare_all();
    chk("rd_ack", o_rd_ack, e_ack[1]);       chk("col_ack", o_col_ack, e_ack[2]);
    chk("scr_ack", o_scr_ack, e_ack[3]);     chk("rd_stall", o_rd_stall, e_stall);
    chk("bram_re", o_bram_re, e_re);         chk("bram_we", o_bram_we, e_we);
    chk("bram_addr", o_bram_addr, e_addr);   chk("bram_wdata", o_bram_wdata, e_wdata);
    chk("rd_valid", o_rd_valid, e_valid[1]); chk("col_valid", o_col_valid, e_valid[2]);
    chk("scr_valid", o_scr_valid, e_valid[3]);
    chk("rd_data", o_rd_data, e_data[1]);    chk("col_data", o_col_data, e_data[2]);
    chk("scr_data", o_scr_data, e_data[3]);
  endtask

  task automatic step();
    model_step();
    @(posedge i_Clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    i_rd_req = 0; i_col_req = 0; i_scr_req = 0; i_scr_we = 0;
    #2;
    i_reset_n = 0;
    model_reset();
    #1;
    compare_all();
    repeat (2) begin
      @(posedge i_Clk);
      #1;
      compare_all();
    end
    @(negedge i_Clk);
    i_reset_n = 1;
  endtask

  typedef struct { logic rd, col, scr; logic [2:0] ack; logic stall; } vec_t;
  vec_t tbl[12];

  initial begin
    // ack field is {scr, col, rd}
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 3'b010, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 3'b100, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 3'b010, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 3'b100, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 3'b001, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 3'b010, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 3'b100, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 3'b010, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 3'b000, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 3'b010, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 3'b100, 1'b0};

    do_reset();

    // Renderer alone: ack after one edge, data two edges later.
    i_rd_req = 1; i_rd_addr = 11'h001;
    step();
    chk("t1_ack", o_rd_ack, 1);
    i_rd_req = 0;
    step();
    step();
    chk("t1_valid", o_rd_valid, 1);
    chk("t1_data", o_rd_data, 16'h3321);
    step();
    chk("t1_valid_end", o_rd_valid, 0);

    // Priority / round-robin / masking table.
    for (int i = 0; i < 12; i++) begin
      i_rd_req = tbl[i].rd; i_col_req = tbl[i].col; i_scr_req = tbl[i].scr; i_scr_we = 0;
      i_rd_addr = 11'(12'h100 + i); i_col_addr = 11'(12'h200 + i); i_scr_addr = 11'(12'h300 + i);
      step();
      chk("tbl_ack", {o_scr_ack, o_col_ack, o_rd_ack}, tbl[i].ack);
      chk("tbl_stall", o_rd_stall, tbl[i].stall);
    end
    i_rd_req = 0; i_col_req = 0; i_scr_req = 0;
    repeat (3) step();

    // Starvation: collision waits 8 edges, then pre-empts the renderer once.
    i_rd_req = 1; i_rd_addr = 11'h040; i_col_req = 1; i_col_addr = 11'h055;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("starve_col_ack", o_col_ack, i == 9);
      chk("starve_stall", o_rd_stall, i == 9);
      chk("starve_rd_ack", o_rd_ack, i != 9);
      if (o_col_ack) i_col_req = 0;
      if (o_rd_ack) i_rd_addr = i_rd_addr + 1'b1;
    end
    i_rd_req = 0; i_col_req = 0;
    repeat (3) step();

    // Scroller write then collision read-back.
    i_scr_req = 1; i_scr_we = 1; i_scr_addr = 11'h014; i_scr_wdata = 16'h1111;
    step();
    chk("wr_we", o_bram_we, 1); chk("wr_re", o_bram_re, 0);
    chk("wr_wdata", o_bram_wdata, 16'h1111); chk("wr_addr", o_bram_addr, 11'h014);
    i_scr_req = 0; i_scr_we = 0;
    step();
    chk("wr_we_end", o_bram_we, 0);
    i_col_req = 1; i_col_addr = 11'h014;
    step();
    chk("rb_ack", o_col_ack, 1);
    i_col_req = 0;
    step();
    step();
    chk("rb_valid", o_col_valid, 1); chk("rb_data", o_col_data, 16'h1111);
    chk("rb_scr_valid", o_scr_valid, 0);

    // Late deassert: request held one edge past its ack is not reissued.
    i_col_req = 1; i_col_addr = 11'h033;
    step();
    chk("late_ack1", o_col_ack, 1);
    step();
    chk("late_ack2", o_col_ack, 0); chk("late_re", o_bram_re, 0);
    i_col_req = 0;
    repeat (3) step();

    // Reset with two reads in flight.
    i_rd_req = 1; i_rd_addr = 11'h077;
    step();
    i_rd_req = 0; i_col_req = 1; i_col_addr = 11'h078;
    step();
    do_reset();
    repeat (4) begin
      step();
      chk("post_rst_valid", {o_rd_valid, o_col_valid, o_scr_valid}, 3'b000);
    end
    i_col_req = 1; i_scr_req = 1; i_scr_we = 0; i_col_addr = 11'h010; i_scr_addr = 11'h011;
    step();
    chk("post_rst_tie_col", o_col_ack, 1); chk("post_rst_tie_scr", o_scr_ack, 0);
    i_col_req = 0;

    // Random traffic against the model, honouring the hold-until-ack rule.
    for (int n = 0; n < 600; n++) begin
      if (!i_rd_req || o_rd_ack) begin
        i_rd_req = ($urandom % 100) < 80; i_rd_addr = 11'($urandom % 32);
      end
      if (!i_col_req || o_col_ack) begin
        i_col_req = ($urandom % 100) < 30; i_col_addr = 11'($urandom % 32);
      end
      if (!i_scr_req || o_scr_ack) begin
        i_scr_req = ($urandom % 100) < 30; i_scr_we = 1'($urandom % 2);
        i_scr_addr = 11'($urandom % 32); i_scr_wdata = 16'($urandom);
      end
      step();
    end
    i_rd_req = 0; i_col_req = 0; i_scr_req = 0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
